// File: rtl/cpu16_pkg.sv
// Shared IRQ arbiter types and constants: line count, idle grant value, FSM state encoding.
// Also a one-hot to index helper used by the round-robin pointer.
package cpu16_pkg;

  localparam int NUM_IRQ = 16;
  localparam logic [NUM_IRQ-1:0] IRQ_NONE = 16'h0000;
  // Line 0 encodes "no interrupt" downstream, so it is never grantable.
  localparam logic [NUM_IRQ-1:0] IRQ_LINE0 = 16'h0001;

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [3:0] onehot_idx(input logic [NUM_IRQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pri_pick16.sv
// Combinational picker: first eligible line searching downward from start, wrapping 1 -> 15.
// Line 0 is never visited; zero latency, result is all-zero when nothing is eligible.
module pri_pick16
  import cpu16_pkg::*;
(
  input  logic [NUM_IRQ-1:0] eligible,
  input  logic [3:0]         start,
  output logic [NUM_IRQ-1:0] pick
);

  logic       found;
  logic [4:0] diff;
  logic [3:0] idx;

  always_comb begin
    pick  = IRQ_NONE;
    found = 1'b0;
    diff  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_IRQ - 1; k++) begin
      diff = {1'b0, start} - 5'(k);
      // Underflow or landing on 0 wraps into the 1..15 range.
      idx  = (diff[4] || (diff == 5'd0)) ? diff[3:0] + 4'd15 : diff[3:0];
      if (!found && eligible[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_onehot_arbiter.sv
// Edge-captured IRQ arbiter: req rise -> pending (+1 edge) -> one-hot grant (+2 edges), held until ack.
// Fixed highest-index priority; define IRQ_ROUND_ROBIN_EN for round-robin selection.
module irq_onehot_arbiter
  import cpu16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               ack,
  output logic [NUM_IRQ-1:0] grant,
  output logic               valid,
  output logic               ovf
);

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] req_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic               ovf_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] pick;
  logic [3:0]         start;

  assign rise     = req & ~req_q;
  assign eligible = pending_q & ~mask & ~IRQ_LINE0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] last_q;

  assign start = (last_q == 4'd1) ? 4'd15 : last_q - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 4'd15;
    end else if (state_q == IDLE && state_d == HOLD) begin
      last_q <= onehot_idx(pick);
    end
  end
`else
  assign start = 4'd15;
`endif

  pri_pick16 u_pick (
    .eligible (eligible),
    .start    (start),
    .pick     (pick)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    clr     = IRQ_NONE;
    case (state_q)
      IDLE: begin
        if (en && (eligible != IRQ_NONE)) begin
          state_d = HOLD;
          grant_d = pick;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          clr     = grant_q;
          state_d = IDLE;
          grant_d = IRQ_NONE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = IRQ_NONE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= IRQ_NONE;
      pending_q <= IRQ_NONE;
      grant_q   <= IRQ_NONE;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      // A fresh edge on the line being acked re-arms it rather than overflowing.
      pending_q <= (pending_q & ~clr) | rise;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_q | (|(rise & pending_q & ~clr));
    end
  end

  assign grant = grant_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule
